lpc_coef_ctrl: RTL and testbench

LPC_COEF_CTRL -- requirements
Module: lpc_coef_ctrl

---
 rtl/lpc_coef_ctrl.sv | 125 ++++++++++++
 tb/tb_lpc_coef_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_coef_ctrl.sv
// Coefficient load/stream controller for an LPC coefficient register bank.
// Optional macro LPC_COEF_REVERSE_EN streams the coefficients in descending index order.
module lpc_coef_ctrl #(
    parameter int N_COEF = 10,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic              clear,
    input  logic              start,
    output logic [N_COEF-1:0] wsel,
    output logic [DW-1:0]     wdata,
    output logic [N_COEF-1:0] rsel,
    input  logic [DW-1:0]     rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [3:0]        out_idx,
    output logic              out_last,
    output logic              coef_loaded,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // valid never waits on ready, and the payload is held while valid is high and ready low.
    localparam logic [1:0] LOAD   = 2'd0;
    localparam logic [1:0] FULL   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    localparam logic [3:0]        LAST_SLOT = 4'(N_COEF - 1);
    localparam logic [N_COEF-1:0] ONE_HOT0  = {{(N_COEF-1){1'b0}}, 1'b1};

`ifdef LPC_COEF_REVERSE_EN
    localparam logic [3:0] FIRST_IDX = LAST_SLOT;
    localparam logic [3:0] FINAL_IDX = 4'd0;
`else
    localparam logic [3:0] FIRST_IDX = 4'd0;
    localparam logic [3:0] FINAL_IDX = LAST_SLOT;
`endif

    logic [1:0] state;
    logic [3:0] wcnt;
    logic [3:0] rcnt;
    logic       load_hs;
    logic       out_hs;
    logic [3:0] rcnt_next;

    assign dbg_state = state;

    // Writes are gated by reset and clear so the bank never sees a stray strobe.
    assign load_hs = reset_n && !clear && (state == LOAD) && in_valid;
    assign out_hs  = (state == STREAM) && out_ready;

    assign in_ready  = (state == LOAD);
    assign wsel      = load_hs ? (ONE_HOT0 << wcnt) : '0;
    assign wdata     = in_data;
    assign rsel      = (state == STREAM) ? (ONE_HOT0 << rcnt) : '0;
    assign out_valid = (state == STREAM);
    assign out_data  = (state == STREAM) ? rdata : '0;
    assign out_idx   = rcnt;
    assign out_last  = (state == STREAM) && (rcnt == FINAL_IDX);

`ifdef LPC_COEF_REVERSE_EN
    assign rcnt_next = rcnt - 4'd1;
`else
    assign rcnt_next = rcnt + 4'd1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LOAD;
            wcnt        <= 4'd0;
            rcnt        <= 4'd0;
            coef_loaded <= 1'b0;
            done        <= 1'b0;
        end else if (clear) begin
            state       <= LOAD;
            wcnt        <= 4'd0;
            rcnt        <= 4'd0;
            coef_loaded <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (load_hs) begin
                        if (wcnt == LAST_SLOT) begin
                            state       <= FULL;
                            wcnt        <= 4'd0;
                            coef_loaded <= 1'b1;
                        end else begin
                            wcnt <= wcnt + 4'd1;
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        state <= STREAM;
                        rcnt  <= FIRST_IDX;
                    end
                end
                STREAM: begin
                    if (out_hs) begin
                        if (rcnt == FINAL_IDX) begin
                            state <= FULL;
                            done  <= 1'b1;
                        end else begin
                            rcnt <= rcnt_next;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                    wcnt  <= 4'd0;
                    rcnt  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_coef_ctrl.sv
// Directed bench for lpc_coef_ctrl with a behavioural coefficient bank.
// Follows LPC_COEF_REVERSE_EN for stream order expectations.
module tb_lpc_coef_ctrl;

    localparam int N  = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          clear;
    logic          start;
    logic [N-1:0]  wsel;
    logic [DW-1:0] wdata;
    logic [N-1:0]  rsel;
    logic [DW-1:0] rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    out_idx;
    logic          out_last;
    logic          coef_loaded;
    logic          done;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] bank [N];
    logic [DW-1:0] exp_coef [N];

    always #5 clk = ~clk;

    lpc_coef_ctrl #(.N_COEF(N), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .clear(clear), .start(start),
        .wsel(wsel), .wdata(wdata), .rsel(rsel), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
        .coef_loaded(coef_loaded), .done(done), .dbg_state(dbg_state)
    );

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (wsel[i]) bank[i] <= wdata;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N; i++)
            if (rsel[i]) rdata = bank[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int idx_at(input int k);
`ifdef LPC_COEF_REVERSE_EN
        return N - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic [63:0] oh(input int i);
        logic [63:0] v;
        v = 64'd1 << i;
        return v;
    endfunction

    task automatic load_all(input logic [DW-1:0] base);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = base + DW'(k);
            start    = (k == 3);
            exp_coef[k] = base + DW'(k);
            #1;
            chk("load_wsel", wsel, oh(k));
            chk("load_wdata", wdata, base + DW'(k));
            chk("load_in_ready", in_ready, 1);
            next_cycle();
            if (k == 3) chk("start_ignored_in_load", dbg_state, 0);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        #1;
        chk("loaded_flag", coef_loaded, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_state", dbg_state, 1);
        chk("full_out_valid", out_valid, 0);
        chk("full_rsel", rsel, 0);
        chk("full_wsel", wsel, 0);
    endtask

    // Streams all coefficients; stall_at >= 0 holds out_ready low 3 cycles at that position.
    task automatic stream_all(input int stall_at);
        start     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("start_cycle_out_valid", out_valid, 0);
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = idx_at(k);
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_data", out_data, exp_coef[i]);
                    chk("stall_rsel", rsel, oh(i));
                    chk("stall_out_idx", out_idx, i);
                    next_cycle();
                end
                out_ready = 1'b1;
            end
            #1;
            chk("str_out_valid", out_valid, 1);
            chk("str_out_data", out_data, exp_coef[i]);
            chk("str_out_idx", out_idx, i);
            chk("str_rsel", rsel, oh(i));
            chk("str_out_last", out_last, (k == N - 1));
            chk("str_no_done", done, 0);
            next_cycle();
        end
        #1;
        chk("done_pulse", done, 1);
        chk("back_to_full", dbg_state, 1);
        chk("end_out_valid", out_valid, 0);
        next_cycle();
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
        start = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_wsel", wsel, 0);
        chk("rst_rsel", rsel, 0);
        chk("rst_coef_loaded", coef_loaded, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dbg_state, 0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        chk("idle_wsel", wsel, 0);

        load_all(32'h100);
        stream_all(-1);
        stream_all(4);

        // Abort the stream with clear at position 6.
        start = 1'b1; out_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) clear = 1'b1;
            #1;
            chk("pre_clear_out_data", out_data, exp_coef[idx_at(k)]);
            next_cycle();
        end
        clear = 1'b0;
        #1;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_done", done, 0);
        chk("clr_state", dbg_state, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_coef_loaded", coef_loaded, 0);

        // Clear coincident with the 5th load handshake.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h300 + k;
            clear    = (k == 4);
            #1;
            chk(k == 4 ? "clr_load_wsel" : "part_load_wsel", wsel, k == 4 ? 64'd0 : oh(k));
            next_cycle();
        end
        clear = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_load_state", dbg_state, 0);
        chk("clr_load_loaded", coef_loaded, 0);

        load_all(32'h200);

        // Asynchronous reset mid-stream.
        start = 1'b1; out_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < 3; k++) next_cycle();
        #1;
        chk("pre_rst_out_data", out_data, exp_coef[idx_at(3)]);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_rsel", rsel, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_loaded", coef_loaded, 0);
        chk("mid_rst_state", dbg_state, 0);
        next_cycle();
        reset_n = 1'b1;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        chk("post_rst_start_ignored", dbg_state, 0);
        chk("post_rst_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
